// File: rtl/data_cache_dm.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_dm
// Brief    : Direct-mapped, write-through, read-allocate data cache between
//            the load/store unit and a word-wide memory port. Read hits are
//            served combinationally; misses refill a whole line word by word,
//            stores are written through and merged into the line on a hit.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache_dm #(
    parameter int LINE_COUNT = 16,
    parameter int LINE_WORDS = 4,
    parameter int WORD_BITS  = 32,
    parameter int ADDR_BITS  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_valid,
    output logic                   cpu_ready,
    input  logic                   cpu_we,
    input  logic [ADDR_BITS-1:0]   cpu_addr,
    input  logic [WORD_BITS-1:0]   cpu_wdata,
    input  logic [WORD_BITS/8-1:0] cpu_be,
    output logic [WORD_BITS-1:0]   cpu_rdata,
    input  logic                   flush,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic                   mem_we,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [WORD_BITS-1:0]   mem_wdata,
    output logic [WORD_BITS/8-1:0] mem_be,
    input  logic [WORD_BITS-1:0]   mem_rdata,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);

    localparam int c_BYTES     = WORD_BITS / 8;
    localparam int c_BOFF      = $clog2(c_BYTES);
    localparam int c_WOFF      = $clog2(LINE_WORDS);
    localparam int c_IDX       = $clog2(LINE_COUNT);
    localparam int c_TAG       = ADDR_BITS - c_IDX - c_WOFF - c_BOFF;
    // Word-offset width kept at least 1 bit so single-word lines still elaborate
    localparam int c_OFF_W     = (c_WOFF > 0) ? c_WOFF : 1;
    localparam int c_RAM_DEPTH = LINE_COUNT * LINE_WORDS;
    localparam int c_RAM_W     = $clog2(c_RAM_DEPTH);

    localparam logic [ADDR_BITS-1:0] c_WORD_MASK = ~ADDR_BITS'(c_BYTES - 1);
    localparam logic [ADDR_BITS-1:0] c_LINE_MASK = ~ADDR_BITS'(c_BYTES * LINE_WORDS - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_REFILL = 2'd1;
    localparam logic [1:0] c_ST_WRITE  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [LINE_COUNT-1:0] r_valid;
    logic [c_TAG-1:0]     r_tag_ram [0:LINE_COUNT-1];
    logic [WORD_BITS-1:0] r_data    [0:c_RAM_DEPTH-1];
    logic [c_OFF_W-1:0]   r_cnt;
    logic [31:0]          r_hit_count;
    logic [31:0]          r_miss_count;
    // Set while the load that caused a refill is waiting for its final hit;
    // that completion was already counted as a miss and is not a hit too.
    logic                 r_after_fill;

    logic [c_OFF_W-1:0]   w_offset;
    logic [c_IDX-1:0]     w_index;
    logic [c_TAG-1:0]     w_tag;
    logic                 w_hit;
    logic                 w_last;
    logic [c_RAM_W-1:0]   w_rd_addr;
    logic [c_RAM_W-1:0]   w_fill_addr;
    logic [ADDR_BITS-1:0] w_word_addr;
    logic [ADDR_BITS-1:0] w_refill_addr;
    logic                 w_start_refill;
    logic                 w_load_hit;
    logic                 w_refill_beat;
    logic                 w_refill_done;
    logic                 w_write_done;

    // Address decomposition and tag compare
    assign w_offset      = c_OFF_W'(cpu_addr >> c_BOFF) & c_OFF_W'(LINE_WORDS - 1);
    assign w_index       = c_IDX'(cpu_addr >> (c_BOFF + c_WOFF));
    assign w_tag         = c_TAG'(cpu_addr >> (c_BOFF + c_WOFF + c_IDX));
    assign w_hit         = r_valid[w_index] && (r_tag_ram[w_index] == w_tag);
    assign w_last        = (r_cnt == c_OFF_W'(LINE_WORDS - 1));
    assign w_rd_addr     = c_RAM_W'(w_index) * c_RAM_W'(LINE_WORDS) + c_RAM_W'(w_offset);
    assign w_fill_addr   = c_RAM_W'(w_index) * c_RAM_W'(LINE_WORDS) + c_RAM_W'(r_cnt);
    assign w_word_addr   = cpu_addr & c_WORD_MASK;
    assign w_refill_addr = (cpu_addr & c_LINE_MASK) | (ADDR_BITS'(r_cnt) << c_BOFF);

    assign cpu_rdata  = r_data[w_rd_addr];
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Next-state and handshake outputs; reset forces both handshakes low
    always_comb begin
        w_state_next   = r_state;
        cpu_ready      = 1'b0;
        mem_valid      = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = w_word_addr;
        mem_wdata      = cpu_wdata;
        mem_be         = cpu_be;
        w_start_refill = 1'b0;
        w_load_hit     = 1'b0;
        w_refill_beat  = 1'b0;
        w_refill_done  = 1'b0;
        w_write_done   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // Flush wins over a concurrent request, which simply waits
                if (!flush && cpu_valid) begin
                    if (cpu_we) begin
                        w_state_next = c_ST_WRITE;
                    end else if (w_hit) begin
                        cpu_ready  = 1'b1;
                        w_load_hit = 1'b1;
                    end else begin
                        w_state_next   = c_ST_REFILL;
                        w_start_refill = 1'b1;
                    end
                end
            end
            c_ST_REFILL: begin
                mem_valid = 1'b1;
                mem_addr  = w_refill_addr;
                mem_be    = '1;
                if (mem_ready) begin
                    w_refill_beat = 1'b1;
                    if (w_last) begin
                        w_refill_done = 1'b1;
                        w_state_next  = c_ST_IDLE;
                    end
                end
            end
            c_ST_WRITE: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                if (mem_ready) begin
                    cpu_ready    = 1'b1;
                    w_write_done = 1'b1;
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
        if (reset) begin
            cpu_ready = 1'b0;
            mem_valid = 1'b0;
        end
    end

    // Control state: FSM, valid bits, fill counter and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_valid      <= '0;
            r_cnt        <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_after_fill <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_ST_IDLE && flush) begin
                r_valid <= '0;
            end
            if (w_start_refill) begin
                // Invalidate up front so a partially filled line never hits
                r_valid[w_index] <= 1'b0;
                r_cnt            <= '0;
                r_miss_count     <= r_miss_count + 32'd1;
            end
            if (w_refill_beat) begin
                r_cnt <= r_cnt + c_OFF_W'(1);
            end
            if (w_refill_done) begin
                r_valid[w_index] <= 1'b1;
                r_after_fill     <= 1'b1;
            end
            if (w_load_hit) begin
                r_after_fill <= 1'b0;
                if (!r_after_fill) begin
                    r_hit_count <= r_hit_count + 32'd1;
                end
            end
        end
    end

    // Tag and data arrays: refill writes, byte-merged store hits, never cleared
    always_ff @(posedge clk) begin
        if (!reset && w_refill_beat) begin
            r_data[w_fill_addr] <= mem_rdata;
        end
        if (!reset && w_refill_done) begin
            r_tag_ram[w_index] <= w_tag;
        end
        if (!reset && w_write_done && w_hit) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (cpu_be[b]) begin
                    r_data[w_rd_addr][8*b +: 8] <= cpu_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache_dm.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache_dm
// Brief    : Self-checking bench for data_cache_dm: directed scenarios plus
//            randomized loads/stores/flushes against a line-level cache model
//            and a word-addressed backing memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache_dm;

    typedef logic [68:0] txn_t;   // {we, be, addr, data}

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_ready, cpu_we, flush;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_be, mem_be;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_count, miss_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit resp_en = 1'b0;
    bit stall_en = 1'b0;

    txn_t        exp_q[$];
    txn_t        obs_q[$];
    logic [31:0] bmem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    bit          ref_valid[16];
    logic [23:0] ref_tag[16];
    logic [31:0] ref_line[16][4];
    logic [31:0] ref_hits, ref_misses;

    data_cache_dm dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC3C3_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] bm_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] rm_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    // -1: logs equal, -2: length differs, else first differing entry
    function automatic int log_diff();
        if (obs_q.size() != exp_q.size()) return -2;
        foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Memory responder: decides mem_ready at the falling edge, logs accepted beats
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en) begin
                mem_ready = 1'b0;
                if (mem_valid) begin
                    mem_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                    if (mem_ready) begin
                        if (mem_we) begin
                            bmem[mem_addr] = merge(bm_rd(mem_addr), mem_wdata, mem_be);
                            obs_q.push_back({1'b1, mem_be, mem_addr, mem_wdata});
                        end else begin
                            mem_rdata = bm_rd(mem_addr);
                            obs_q.push_back({1'b0, 4'h0, mem_addr, 32'h0});
                        end
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic ref_reset();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        ref_hits = 0;
        ref_misses = 0;
    endtask

    task automatic ref_flush();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic ref_load(input logic [31:0] a, output logic [31:0] d, output bit hit);
        int idx, off;
        logic [31:0] base;
        idx  = int'(a[7:4]);
        off  = int'(a[3:2]);
        base = {a[31:4], 4'h0};
        exp_q.delete();
        hit = ref_valid[idx] && (ref_tag[idx] == a[31:8]);
        if (hit) begin
            ref_hits++;
        end else begin
            ref_misses++;
            for (int w = 0; w < 4; w++) begin
                ref_line[idx][w] = rm_rd(base + 32'(4 * w));
                exp_q.push_back({1'b0, 4'h0, base + 32'(4 * w), 32'h0});
            end
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[31:8];
        end
        d = ref_line[idx][off];
    endtask

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        int idx, off;
        logic [31:0] wa;
        idx = int'(a[7:4]);
        off = int'(a[3:2]);
        wa  = {a[31:2], 2'b00};
        exp_q.delete();
        exp_q.push_back({1'b1, be, wa, wd});
        ref_mem[wa] = merge(rm_rd(wa), wd, be);
        if (ref_valid[idx] && ref_tag[idx] == a[31:8])
            ref_line[idx][off] = merge(ref_line[idx][off], wd, be);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        bmem[a] = v;
        ref_mem[a] = v;
    endtask

    // ---------------- drivers ----------------
    task automatic cpu_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output int cyc);
        obs_q.delete();
        @(posedge clk); #1;
        cpu_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        cyc = 0;
        rdata = 'x;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (cpu_ready) begin
                rdata = cpu_rdata;
                break;
            end
            if (cyc >= 200) begin
                n_cmp++; n_bad++;
                $display("FAIL access_timeout: addr %h no cpu_ready after %0d cycles", addr, cyc);
                break;
            end
        end
        @(posedge clk); #1;
        cpu_valid = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        ref_flush();
    endtask

    task automatic beat(input bit rdy);
        @(negedge clk);
        mem_ready = rdy;
        if (rdy && mem_valid && !mem_we) mem_rdata = bm_rd(mem_addr);
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; mem_ready = 1'b1; mem_rdata = '0;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0; cpu_be = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        n_cmp++;
        if ({cpu_ready, mem_valid} !== 2'b00) begin
            n_bad++; $display("FAIL reset_handshake: got %b want 00", {cpu_ready, mem_valid});
        end
        @(posedge clk); #1;
        reset = 1'b0; cpu_valid = 1'b0; mem_ready = 1'b0;
        ref_reset();
        @(negedge clk); #2;
        n_cmp++;
        if ({hit_count, miss_count, mem_valid} !== 65'd0) begin
            n_bad++; $display("FAIL reset_counters: got %0d/%0d/%b want 0/0/0", hit_count, miss_count, mem_valid);
        end
    endtask

    task automatic test_fill_and_hit();
        logic [31:0] d, rd; bit h; int cyc, ld;
        for (int i = 0; i < 4; i++) preload(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        ref_load(32'h100, d, h);
        cpu_access(1'b0, 32'h100, '0, '0, rd, cyc);
        ld = log_diff();
        n_cmp++;
        if (ld !== -1) begin n_bad++; $display("FAIL fill_memlog: diff code %0d want -1 (got %0d beats)", ld, obs_q.size()); end
        n_cmp++;
        if (rd !== 32'hA0) begin n_bad++; $display("FAIL fill_rdata: got %h want %h", rd, 32'hA0); end
        n_cmp++;
        if (cyc !== 6) begin n_bad++; $display("FAIL fill_latency: got %0d want 6", cyc); end
        n_cmp++;
        if (miss_count !== 32'd1) begin n_bad++; $display("FAIL fill_miss_count: got %0d want 1", miss_count); end
        ref_load(32'h108, d, h);
        cpu_access(1'b0, 32'h108, '0, '0, rd, cyc);
        n_cmp++;
        if ({cyc == 1, rd} !== {1'b1, 32'hA2}) begin n_bad++; $display("FAIL hit_same_cycle: got cyc %0d rd %h want 1 %h", cyc, rd, 32'hA2); end
        n_cmp++;
        if (obs_q.size() !== 0) begin n_bad++; $display("FAIL hit_no_mem: got %0d beats want 0", obs_q.size()); end
        n_cmp++;
        if (hit_count !== 32'd1) begin n_bad++; $display("FAIL hit_count: got %0d want 1", hit_count); end
    endtask

    task automatic test_store_hit();
        logic [31:0] d, rd; bit h; int cyc, ld;
        ref_store(32'h104, 32'h1234_5678, 4'b0011);
        cpu_access(1'b1, 32'h104, 32'h1234_5678, 4'b0011, rd, cyc);
        ld = log_diff();
        n_cmp++;
        if (ld !== -1 || cyc !== 2) begin n_bad++; $display("FAIL store_hit_write: diff %0d cyc %0d want -1 2", ld, cyc); end
        ref_load(32'h104, d, h);
        cpu_access(1'b0, 32'h104, '0, '0, rd, cyc);
        n_cmp++;
        if (rd !== 32'h0000_5678 || cyc !== 1) begin n_bad++; $display("FAIL store_hit_merge: got %h cyc %0d want 00005678 1", rd, cyc); end
    endtask

    task automatic test_store_miss();
        logic [31:0] d, rd; bit h; int cyc, ld;
        ref_store(32'h200, 32'hDEAD_BEEF, 4'b1111);
        cpu_access(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b1111, rd, cyc);
        ld = log_diff();
        n_cmp++;
        if (ld !== -1) begin n_bad++; $display("FAIL store_miss_write: diff %0d want -1", ld); end
        ref_load(32'h200, d, h);
        cpu_access(1'b0, 32'h200, '0, '0, rd, cyc);
        ld = log_diff();
        n_cmp++;
        if (ld !== -1 || rd !== 32'hDEAD_BEEF || cyc !== 6) begin
            n_bad++; $display("FAIL store_no_alloc: diff %0d rd %h cyc %0d want -1 deadbeef 6", ld, rd, cyc);
        end
        n_cmp++;
        if (miss_count !== ref_misses) begin n_bad++; $display("FAIL store_miss_count: got %0d want %0d", miss_count, ref_misses); end
    endtask

    task automatic test_conflict();
        logic [31:0] d, rd; bit h; int cyc, ld;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] a;
            a = (k == 0) ? 32'h900 : 32'h100;
            ref_load(a, d, h);
            cpu_access(1'b0, a, '0, '0, rd, cyc);
            ld = log_diff();
            n_cmp++;
            if (ld !== -1 || rd !== d || cyc !== 6) begin
                n_bad++; $display("FAIL conflict_%h: diff %0d rd %h cyc %0d want -1 %h 6", a, ld, rd, cyc, d);
            end
        end
        n_cmp++;
        if (rd !== 32'hA0) begin n_bad++; $display("FAIL conflict_refetch: got %h want a0", rd); end
    endtask

    task automatic test_flush();
        logic [31:0] d, rd; bit h; int cyc;
        @(posedge clk); #1;
        flush = 1'b1; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        @(negedge clk); #2;
        n_cmp++;
        if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL flush_priority: got cpu_ready %b want 0", cpu_ready); end
        @(posedge clk); #1;
        flush = 1'b0; cpu_valid = 1'b0;
        ref_flush();
        ref_load(32'h100, d, h);
        cpu_access(1'b0, 32'h100, '0, '0, rd, cyc);
        n_cmp++;
        if (cyc !== 6 || rd !== d) begin n_bad++; $display("FAIL flush_then_miss: cyc %0d rd %h want 6 %h", cyc, rd, d); end
        // Flush raised during a refill must not disturb it
        ref_load(32'h500, d, h);
        fork
            cpu_access(1'b0, 32'h500, '0, '0, rd, cyc);
            begin
                @(posedge clk); @(posedge clk); #1; flush = 1'b1;
                repeat (2) @(posedge clk); #1; flush = 1'b0;
            end
        join
        ref_load(32'h504, d, h);
        cpu_access(1'b0, 32'h504, '0, '0, rd, cyc);
        n_cmp++;
        if (cyc !== 1 || rd !== d) begin n_bad++; $display("FAIL flush_in_refill: cyc %0d rd %h want 1 %h", cyc, rd, d); end
    endtask

    task automatic test_mem_stall();
        logic [31:0] d; bit h;
        resp_en = 1'b0; mem_ready = 1'b0;
        ref_load(32'h100, d, h);
        @(posedge clk); #1;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        beat(1'b0);
        beat(1'b1);
        n_cmp++;
        if ({mem_valid, mem_addr} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL stall_word0: got %b %h want 1 00000100", mem_valid, mem_addr); end
        for (int i = 0; i < 3; i++) begin
            beat(1'b0);
            n_cmp++;
            if ({mem_valid, mem_we, mem_addr} !== {2'b10, 32'h104}) begin
                n_bad++; $display("FAIL stall_hold_%0d: got %b %b %h want 1 0 00000104", i, mem_valid, mem_we, mem_addr);
            end
        end
        beat(1'b1); beat(1'b1); beat(1'b1);
        beat(1'b0);
        n_cmp++;
        if ({cpu_ready, cpu_rdata} !== {1'b1, d}) begin n_bad++; $display("FAIL stall_result: got %b %h want 1 %h", cpu_ready, cpu_rdata, d); end
        @(posedge clk); #1;
        cpu_valid = 1'b0;
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] d, rd; bit h; int cyc;
        resp_en = 1'b0; mem_ready = 1'b0;
        do_flush();
        @(posedge clk); #1;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        beat(1'b0); beat(1'b1); beat(1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        beat(1'b1);
        n_cmp++;
        if ({mem_valid, cpu_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_abort: got %b want 00", {mem_valid, cpu_ready}); end
        @(posedge clk); #1;
        reset = 1'b0; cpu_valid = 1'b0; mem_ready = 1'b0;
        ref_reset();
        resp_en = 1'b1;
        ref_load(32'h100, d, h);
        cpu_access(1'b0, 32'h100, '0, '0, rd, cyc);
        n_cmp++;
        if (log_diff() !== -1 || (obs_q.size() > 0 && obs_q[0][63:32] !== 32'h100)) begin
            n_bad++; $display("FAIL reset_refetch: got %0d beats want 4 from 00000100", obs_q.size());
        end
        n_cmp++;
        if ({rd, miss_count, hit_count} !== {d, 32'd1, 32'd0}) begin
            n_bad++; $display("FAIL reset_refetch_data: got %h %0d %0d want %h 1 0", rd, miss_count, hit_count, d);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, rd, a, wd; logic [3:0] be; bit h; int cyc, ld, op;
        resp_en = 1'b1; stall_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if (op == 0) begin
                do_flush();
            end else if (op < 4) begin
                wd = $urandom;
                be = 4'($urandom_range(0, 15));
                ref_store(a, wd, be);
                cpu_access(1'b1, a, wd, be, rd, cyc);
                ld = log_diff();
                n_cmp++;
                if (ld !== -1) begin n_bad++; $display("FAIL rand_store_%0d: addr %h diff %0d want -1", n, a, ld); end
            end else begin
                ref_load(a, d, h);
                cpu_access(1'b0, a, '0, '0, rd, cyc);
                ld = log_diff();
                n_cmp++;
                if (rd !== d || (cyc == 1) !== h || ld !== -1) begin
                    n_bad++; $display("FAIL rand_load_%0d: addr %h rd %h hit %0d diff %0d want %h %0d -1", n, a, rd, cyc == 1, ld, d, h);
                end
            end
            n_cmp++;
            if ({hit_count, miss_count} !== {ref_hits, ref_misses}) begin
                n_bad++; $display("FAIL rand_counts_%0d: got %0d/%0d want %0d/%0d", n, hit_count, miss_count, ref_hits, ref_misses);
            end
        end
        stall_en = 1'b0;
    endtask

    initial begin
        test_reset();
        resp_en = 1'b1;
        test_fill_and_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_flush();
        test_mem_stall();
        test_reset_mid_refill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
